// File: rtl/cim_pkg.sv
// Shared definitions for the CIM weight-loading path: default geometry,
// loader state encoding and ping/pong row-select constants.
package cim_pkg;

    // Default bank geometry: 144 rows per bank, 8 bit-slice banks.
    localparam int ROWS_DEF       = 144;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int BANKS_DEF      = 8;

    // Loader FSM encoding.
    typedef enum logic {
        LOAD      = 1'b0,
        WAIT_SWAP = 1'b1
    } loader_state_e;

    // Row-select values shared by the writer and the MAC datapath.
    localparam logic ROW_PING = 1'b0;
    localparam logic ROW_PONG = 1'b1;

    // The row being written is always the one the MAC is not reading.
    function automatic logic shadow_row(input logic active);
        return ~active;
    endfunction

endpackage : cim_pkg

// File: rtl/cim_weight_loader.sv
// Weight loader for the CIM bit-slice banks. Accepts one weight word per row,
// broadcasts it as a single registered write to all banks, and manages the
// ping/pong swap between the shadow row (being written) and the active row
// (being read by the MAC).
module cim_weight_loader
    import cim_pkg::*;
#(
    parameter int ROWS       = ROWS_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BANKS      = BANKS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BANKS-1:0]      s_data,
    input  logic                  s_last,
    input  logic                  mac_release,
    output logic                  bank_we,
    output logic [ADDR_WIDTH-1:0] bank_wa,
    output logic [BANKS-1:0]      bank_d,
    output logic                  bank_write_to_pong_row,
    output logic                  active_row,
    output logic                  active_valid,
    output logic                  load_done,
    output logic                  frame_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROWS - 1);

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  release_pending_q, release_pending_d;

    logic                  bank_we_q, bank_we_d;
    logic [ADDR_WIDTH-1:0] bank_wa_q, bank_wa_d;
    logic [BANKS-1:0]      bank_d_q, bank_d_d;
    logic                  pong_q, pong_d;
    logic                  active_row_q, active_row_d;
    logic                  active_valid_q, active_valid_d;
    logic                  load_done_q, load_done_d;
    logic                  frame_err_q, frame_err_d;

    logic                  accept;
    logic                  at_last;
    logic                  swap;

    assign accept  = s_valid & s_ready;
    assign at_last = (addr_q == LAST_ADDR);
    // A swap may happen once the shadow row is full and either nothing valid
    // is being read yet or the MAC has released (now or earlier).
    assign swap    = (state_q == WAIT_SWAP) &&
                     (!active_valid_q || mac_release || release_pending_q);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fill a full frame, then hold until the swap is allowed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:      if (accept && at_last) state_d = WAIT_SWAP;
            WAIT_SWAP: if (swap)              state_d = LOAD;
            default:                          state_d = LOAD;
        endcase
    end

    // FSM outputs: the only combinational output, ready while loading.
    always_comb begin
        s_ready = (state_q == LOAD);
    end

    // Next values for the address counter, write port and row bookkeeping.
    always_comb begin
        addr_d            = addr_q;
        bank_we_d         = accept;
        bank_wa_d         = bank_wa_q;
        bank_d_d          = bank_d_q;
        pong_d            = pong_q;
        active_row_d      = active_row_q;
        active_valid_d    = active_valid_q;
        load_done_d       = swap;
        frame_err_d       = 1'b0;
        release_pending_d = release_pending_q;

        if (accept) begin
            // Frame length is fixed at ROWS words; s_last only flags mismatches.
            addr_d      = at_last ? '0 : addr_q + 1'b1;
            bank_wa_d   = addr_q;
            bank_d_d    = s_data;
            pong_d      = shadow_row(active_row_q);
            frame_err_d = (s_last != at_last);
        end

        if (swap) begin
            active_row_d      = ~active_row_q;
            active_valid_d    = 1'b1;
            release_pending_d = 1'b0;
        end else if (mac_release) begin
            // Early release is remembered so the swap fires at frame end.
            release_pending_d = 1'b1;
        end
    end

    // Registered datapath and row state; everything returns to reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q            <= '0;
            release_pending_q <= 1'b0;
            bank_we_q         <= 1'b0;
            bank_wa_q         <= '0;
            bank_d_q          <= '0;
            pong_q            <= ROW_PONG;
            active_row_q      <= ROW_PING;
            active_valid_q    <= 1'b0;
            load_done_q       <= 1'b0;
            frame_err_q       <= 1'b0;
        end else begin
            addr_q            <= addr_d;
            release_pending_q <= release_pending_d;
            bank_we_q         <= bank_we_d;
            bank_wa_q         <= bank_wa_d;
            bank_d_q          <= bank_d_d;
            pong_q            <= pong_d;
            active_row_q      <= active_row_d;
            active_valid_q    <= active_valid_d;
            load_done_q       <= load_done_d;
            frame_err_q       <= frame_err_d;
        end
    end

    assign bank_we                = bank_we_q;
    assign bank_wa                = bank_wa_q;
    assign bank_d                 = bank_d_q;
    assign bank_write_to_pong_row = pong_q;
    assign active_row             = active_row_q;
    assign active_valid           = active_valid_q;
    assign load_done              = load_done_q;
    assign frame_err              = frame_err_q;

endmodule : cim_weight_loader

// File: tb/tb_cim_weight_loader.sv
// Self-checking bench for cim_weight_loader: drives frames of weight words
// and compares bank writes, swaps and frame errors against a queue-based
// reference of what each accepted word must produce.
module tb_cim_weight_loader;

    localparam int ROWS   = 144;
    localparam int ADDR_W = 8;
    localparam int BANKS  = 8;

    typedef logic [ADDR_W+BANKS:0] wr_t; // {pong, addr, data}

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [BANKS-1:0]  s_data = '0;
    logic              s_last = 1'b0;
    logic              mac_release = 1'b0;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_wa;
    logic [BANKS-1:0]  bank_d;
    logic              bank_write_to_pong_row;
    logic              active_row;
    logic              active_valid;
    logic              load_done;
    logic              frame_err;

    int checks = 0;
    int passes = 0;

    // Reference model state.
    int   exp_idx    = 0;    // word position within the current frame
    logic exp_active = 1'b0; // row the MAC should be reading
    wr_t  exp_q[$];
    wr_t  wr_q[$];
    int   err_q[$];
    int   swaps = 0;

    cim_weight_loader #(.ROWS(ROWS), .ADDR_WIDTH(ADDR_W), .BANKS(BANKS)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_valid                (s_valid),
        .s_ready                (s_ready),
        .s_data                 (s_data),
        .s_last                 (s_last),
        .mac_release            (mac_release),
        .bank_we                (bank_we),
        .bank_wa                (bank_wa),
        .bank_d                 (bank_d),
        .bank_write_to_pong_row (bank_write_to_pong_row),
        .active_row             (active_row),
        .active_valid           (active_valid),
        .load_done              (load_done),
        .frame_err              (frame_err)
    );

    always #5 clk = ~clk;

    // Monitor: log every bank write, swap pulse and frame error.
    always begin
        @(posedge clk);
        #1;
        if (bank_we === 1'b1) wr_q.push_back({bank_write_to_pong_row, bank_wa, bank_d});
        if (load_done === 1'b1) swaps++;
        if (frame_err === 1'b1) err_q.push_back(int'(bank_wa));
    end

    function automatic int write_diffs();
        int n = 0;
        if (wr_q.size() != exp_q.size()) n++;
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic clear_logs();
        wr_q.delete();
        exp_q.delete();
        err_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid     = 1'b0;
            s_last      = 1'b0;
            mac_release = 1'b0;
            @(posedge clk);
        end
    endtask

    // Present one word and wait (bounded) until it is accepted.
    task automatic send_word(input logic [BANKS-1:0] d, input logic last, input logic rel);
        bit done = 1'b0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = last; mac_release = rel;
        for (int c = 0; c < 400 && !done; c++) begin
            if (s_ready === 1'b1) begin
                @(posedge clk);
                exp_q.push_back({~exp_active, ADDR_W'(exp_idx), d});
                exp_idx = (exp_idx + 1) % ROWS;
                done = 1'b1;
            end else begin
                @(posedge clk);
                @(negedge clk);
                mac_release = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL send_word_accept: s_ready never rose within 400 cycles, required 1");
        end
    endtask

    task automatic send_frame(input int rel_at, input int idle_pct, input bit rnd,
                              input int bad_last_at, input bit drop_last);
        for (int i = 0; i < ROWS; i++) begin
            logic [BANKS-1:0] d;
            logic             l;
            if (idle_pct > 0 && int'($urandom_range(99)) < idle_pct) idle(1);
            d = rnd ? BANKS'($urandom) : BANKS'(i);
            l = (i == ROWS - 1) ? !drop_last : (i == bad_last_at);
            send_word(d, l, i == rel_at);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({bank_we, bank_wa, bank_d} !== '0) $display("FAIL rst_write_port: got %0h required 0", {bank_we, bank_wa, bank_d}); else passes++;
        checks++; if (bank_write_to_pong_row !== 1'b1) $display("FAIL rst_pong_sel: got %b required 1", bank_write_to_pong_row); else passes++;
        checks++; if ({active_row, active_valid, load_done, frame_err} !== 4'b0) $display("FAIL rst_row_flags: got %b required 0000", {active_row, active_valid, load_done, frame_err}); else passes++;
        checks++; if (s_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", s_ready); else passes++;
        @(negedge clk);
        rst = 1'b0;
        exp_idx = 0; exp_active = 1'b0;
        clear_logs();
    endtask

    task automatic test_first_frame();
        int d;
        clear_logs();
        send_frame(-1, 0, 1'b0, -1, 1'b0);
        #1;
        checks++; if (s_ready !== 1'b0) $display("FAIL ff_ready_wait: got %b required 0", s_ready); else passes++;
        checks++; if ({bank_we, bank_wa} !== {1'b1, 8'd143}) $display("FAIL ff_last_write: got we=%b wa=%0d required we=1 wa=143", bank_we, bank_wa); else passes++;
        checks++; if ({active_row, active_valid} !== 2'b00) $display("FAIL ff_no_early_swap: got %b required 00", {active_row, active_valid}); else passes++;
        idle(1); #1;
        checks++; if ({active_row, active_valid, load_done} !== 3'b111) $display("FAIL ff_swap: got %b required 111", {active_row, active_valid, load_done}); else passes++;
        exp_active = 1'b1;
        idle(1); #1;
        checks++; if ({load_done, s_ready} !== 2'b01) $display("FAIL ff_after_swap: got %b required 01", {load_done, s_ready}); else passes++;
        d = write_diffs();
        checks++; if (d !== 0) $display("FAIL ff_writes: got %0d diffs (%0d writes) required 0 diffs (%0d writes)", d, wr_q.size(), exp_q.size()); else passes++;
        checks++; if (err_q.size() !== 0) $display("FAIL ff_frame_err: got %0d errors required 0", err_q.size()); else passes++;
    endtask

    task automatic test_hold_no_release();
        int d, s0;
        clear_logs();
        s0 = swaps;
        send_frame(-1, 0, 1'b1, -1, 1'b0);
        idle(20); #1;
        checks++; if ({active_row, s_ready} !== 2'b10) $display("FAIL hold_wait: got row/ready=%b required 10", {active_row, s_ready}); else passes++;
        checks++; if (swaps - s0 !== 0) $display("FAIL hold_no_swap: got %0d swaps required 0", swaps - s0); else passes++;
        @(negedge clk); mac_release = 1'b1;
        @(posedge clk); #1;
        checks++; if ({active_row, active_valid, load_done} !== 3'b011) $display("FAIL hold_release_swap: got %b required 011", {active_row, active_valid, load_done}); else passes++;
        exp_active = 1'b0;
        idle(2);
        d = write_diffs();
        checks++; if (d !== 0) $display("FAIL hold_writes: got %0d diffs required 0", d); else passes++;
    endtask

    task automatic test_early_release();
        int d, s0;
        clear_logs();
        s0 = swaps;
        send_frame(50, 0, 1'b1, -1, 1'b0);
        #1;
        checks++; if ({active_row, s_ready} !== 2'b00) $display("FAIL early_wait: got %b required 00", {active_row, s_ready}); else passes++;
        idle(1); #1;
        checks++; if ({active_row, load_done} !== 2'b11) $display("FAIL early_auto_swap: got %b required 11", {active_row, load_done}); else passes++;
        exp_active = 1'b1;
        idle(2); #1;
        checks++; if (swaps - s0 !== 1) $display("FAIL early_swap_count: got %0d required 1", swaps - s0); else passes++;
        d = write_diffs();
        checks++; if (d !== 0) $display("FAIL early_writes: got %0d diffs required 0", d); else passes++;
    endtask

    task automatic test_frame_err();
        int d, e0, e1;
        clear_logs();
        send_frame(0, 0, 1'b1, 10, 1'b1);
        idle(1); #1;
        checks++; if (active_row !== 1'b0) $display("FAIL ferr_swap: got %b required 0", active_row); else passes++;
        exp_active = 1'b0;
        idle(2);
        e0 = (err_q.size() > 0) ? err_q[0] : -1;
        e1 = (err_q.size() > 1) ? err_q[1] : -1;
        checks++; if (err_q.size() !== 2) $display("FAIL ferr_count: got %0d required 2", err_q.size()); else passes++;
        checks++; if ({e0, e1} !== {32'sd10, 32'sd143}) $display("FAIL ferr_positions: got %0d,%0d required 10,143", e0, e1); else passes++;
        d = write_diffs();
        checks++; if (d !== 0) $display("FAIL ferr_writes: got %0d diffs (%0d writes) required 0 diffs", d, wr_q.size()); else passes++;
    endtask

    task automatic test_random_gaps();
        int d;
        clear_logs();
        send_frame(0, 30, 1'b1, -1, 1'b0);
        idle(1); #1;
        checks++; if (active_row !== 1'b1) $display("FAIL gaps_swap: got %b required 1", active_row); else passes++;
        exp_active = 1'b1;
        idle(2);
        d = write_diffs();
        checks++; if (d !== 0) $display("FAIL gaps_writes: got %0d diffs (%0d writes) required 0 diffs (%0d writes)", d, wr_q.size(), exp_q.size()); else passes++;
        checks++; if (err_q.size() !== 0) $display("FAIL gaps_frame_err: got %0d required 0", err_q.size()); else passes++;
    endtask

    task automatic test_reset_midframe();
        int d;
        wr_t w0;
        clear_logs();
        for (int i = 0; i < 70; i++) send_word(BANKS'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if ({bank_we, bank_wa, bank_d} !== '0) $display("FAIL mid_rst_write_port: got %0h required 0", {bank_we, bank_wa, bank_d}); else passes++;
        checks++; if ({bank_write_to_pong_row, active_row, active_valid, load_done, frame_err} !== 5'b10000) $display("FAIL mid_rst_flags: got %b required 10000", {bank_write_to_pong_row, active_row, active_valid, load_done, frame_err}); else passes++;
        checks++; if (s_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b required 1", s_ready); else passes++;
        @(negedge clk);
        rst = 1'b0;
        exp_idx = 0; exp_active = 1'b0;
        clear_logs();
        send_frame(-1, 0, 1'b1, -1, 1'b0);
        w0 = (wr_q.size() > 0) ? wr_q[0] : '0;
        checks++; if (w0[ADDR_W+BANKS:BANKS] !== {1'b1, 8'd0}) $display("FAIL mid_restart: got pong/wa=%0h required 100", w0[ADDR_W+BANKS:BANKS]); else passes++;
        idle(1); #1;
        checks++; if ({active_row, active_valid} !== 2'b11) $display("FAIL mid_swap: got %b required 11", {active_row, active_valid}); else passes++;
        exp_active = 1'b1;
        idle(2);
        d = write_diffs();
        checks++; if (d !== 0) $display("FAIL mid_writes: got %0d diffs required 0", d); else passes++;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_hold_no_release();
        test_early_release();
        test_frame_err();
        test_random_gaps();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_cim_weight_loader
